reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  Receiving end of the decode-to-RS dispatch interface: one instance per whichMath class (4 total).
//  Buffers dispatched ops and snoops the CDB for missing operands.
//  Issues the oldest ready op to its execution unit through a valid/ready output register.
//  stall_o feeds back to decode's stall OR.
// PARAMETERS
//  ROBsize     32                    ROB depth
//  ROBsizeLog  $clog2(ROBsize+1)     tag width; tag 0 = "operand present, no dependency"
//  RSentries   4                     buffer depth (>=2)
// PORTS
//  clk_i            in   1           single clock, rising edge
//  reset_i          in   1           asynchronous, active-low reset
//  writeEn_i        in   1           dispatch strobe (decode already gates it with ~stall)
//  robTag_i         in   ROBsizeLog  destination ROB tag of dispatched op
//  tag1_i, tag2_i   in   ROBsizeLog  producer tags for operand 1/2; 0 = value already valid
//  val1_i, val2_i   in   65          operand values; bit 64 stored, never interpreted
//  commands_i       in   10          control bits {read_en,saveCond,lShift,fwd,regWrite,ALUOp[2:0],memToReg,memWrite}
//  stall_o          out  1           buffer full
//  flush_i          in   1           synchronous squash of all state
//  cdbValid_i       in   1           CDB broadcast valid
//  cdbTag_i         in   ROBsizeLog  CDB producer tag (never 0 when valid)
//  cdbData_i        in   64          CDB result
//  issueValid_o     out  1           output register holds an op
//  issueReady_i     in   1           execution unit accepts op this cycle
//  issueTag_o       out  ROBsizeLog  ROB tag of issued op
//  issueVal1_o      out  64          operand 1 of issued op
//  issueVal2_o      out  64          operand 2 of issued op
//  issueCmd_o       out  10          commands of issued op
// BEHAVIOUR
//  Reset: all entries invalid, count=0, stall_o=0, issueValid_o=0, all issue data outputs 0.
//  Storage: collapsing queue; index 0 = oldest; entries [0,count) valid.
//   Per entry: robTag, tag1, tag2, val1, val2, cmd. An entry is ready when tag1==0 and tag2==0.
//  stall_o = (count==RSentries), computed from registered count only.
//   A same-cycle issue does not drop stall_o; it falls the following cycle.
//  Dispatch: writeEn_i & ~stall_o appends at index count (post-collapse index if an issue also occurs).
//   writeEn_i while full: ignored and state unchanged; assertion error in sim.
//  Dispatch bypass: if cdbValid_i and cdbTag_i==tag1_i (or tag2_i), nonzero, the entry stores cdbData_i
//   for that operand, with tag set to 0.
//  Wakeup: each valid entry with tagN==cdbTag_i (nonzero, cdbValid_i) captures cdbData_i into valN[63:0]
//   and clears tagN to 0 at the edge. Both operands may wake in one cycle.
//  Select: lowest-index ready entry, evaluated on registered entry state.
//   Taken when the output register is free: ~issueValid_o | issueReady_i.
//   At the edge: the output register loads the entry, entries above it shift down by one, count-1.
//  Output register: issueValid_o holds with stable data until issueReady_i.
//   issueValid_o & issueReady_i with no new select -> issueValid_o=0 next cycle.
//  Latency: dispatch with both tags 0 at edge E -> issueValid_o=1 after E+1.
//   CDB wakeup at edge E -> issue after E+1. Never issues in its dispatch cycle.
//  Simultaneous dispatch+issue: count unchanged; new entry lands at old count-1.
//  Flush: next edge clears entries, count and output register; overrides dispatch, issue and wakeup.
//  Reset mid-operation: immediate return to reset state; in-flight output op is lost.
//  Wakeup is tag-equality only; tags wrap mod ROBsize, and the ROB guarantees tag uniqueness in flight.
// STRUCTURE
//  rs_pkg: rs_entry_t struct, rob_tag_t typedef, CMD_* bit index constants.
//   Parameterise the tag width as ROBsizeLog.
//  Sub-module rs_ready_picker: RSentries ready vector -> one-hot + index of lowest set bit, plus any-ready.
//  Everything else (queue, wakeup, collapse, output reg) lives in this module.
// TESTING
//  1 Dispatch tag1=0,tag2=0,robTag=5,val1=3,val2=4, issueReady=1
//    -> next cycle issueValid=1, tag=5, val1=3, val2=4; count returns 0.
//  2 Dispatch tag1=7, then cdbValid=1,cdbTag=7,cdbData=0xAA two cycles later
//    -> issue one cycle after CDB edge, val1=0xAA.
//  3 Dispatch with tag2=9 while CDB broadcasts tag 9 data 0x55 same cycle
//    -> entry ready immediately, issues next cycle with val2=0x55.
//  4 Fill 4 blocked entries -> stall_o=1; extra writeEn ignored.
//    Wake entry 2 -> it issues, stall_o=0 the following cycle, order of others preserved.
//  5 issueReady=0 for 3 cycles with 2 ready entries -> outputs stable;
//    raise ready -> oldest then next issue back-to-back.
//  6 flush_i with 3 entries and issueValid=1 -> next cycle count=0, issueValid=0.
//    Async reset_i low mid-stream -> all outputs 0 immediately.

Source files
------------

// File: rtl/rs_pkg.sv
// Shared types for the reservation station: ROB tag type, entry record,
// command bit positions and the CDB tag-match helper.
package rs_pkg;

  localparam int ROBsize    = 32;
  localparam int ROBsizeLog = $clog2(ROBsize + 1);
  localparam int CMD_W      = 10;

  // Bit positions inside commands {read_en,saveCond,lShift,fwd,regWrite,ALUOp[2:0],memToReg,memWrite}
  localparam int CMD_MEMWRITE  = 0;
  localparam int CMD_MEMTOREG  = 1;
  localparam int CMD_ALUOP_LSB = 2;
  localparam int CMD_ALUOP_MSB = 4;
  localparam int CMD_REGWRITE  = 5;
  localparam int CMD_FWD       = 6;
  localparam int CMD_LSHIFT    = 7;
  localparam int CMD_SAVECOND  = 8;
  localparam int CMD_READ_EN   = 9;

  // Tag 0 means "operand present, no producer outstanding"
  typedef logic [ROBsizeLog-1:0] rob_tag_t;

  typedef struct packed {
    rob_tag_t         rob_tag;
    rob_tag_t         tag1;
    rob_tag_t         tag2;
    logic [64:0]      val1;
    logic [64:0]      val2;
    logic [CMD_W-1:0] cmd;
  } rs_entry_t;

  // A waiting operand matches a broadcast only on a valid, nonzero tag
  function automatic logic tag_hit(input logic cdb_valid, input rob_tag_t cdb_tag,
                                   input rob_tag_t tag);
    return cdb_valid && (cdb_tag != '0) && (cdb_tag == tag);
  endfunction

endpackage

// File: rtl/rs_ready_picker.sv
// Priority picker: lowest-index set bit of the ready vector, as one-hot and
// as a binary index, plus an any-ready flag.
module rs_ready_picker #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     ready,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] index,
  output logic             any_ready
);

  // Isolate the lowest set bit
  assign onehot    = ready & (~ready + N'(1));
  assign any_ready = |ready;

  // Scan from the top so the lowest ready index wins
  always_comb begin
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) index = IDX_W'(i);
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Reservation station: collapsing queue of dispatched ops (index 0 oldest),
// CDB snooping for missing operands, oldest-ready select into a valid/ready
// output register.
module reservation_station
  import rs_pkg::*;
#(
  parameter int RSentries = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              writeEn_i,
  input  logic [ROBsizeLog-1:0] robTag_i,
  input  logic [ROBsizeLog-1:0] tag1_i,
  input  logic [ROBsizeLog-1:0] tag2_i,
  input  logic [64:0]       val1_i,
  input  logic [64:0]       val2_i,
  input  logic [9:0]        commands_i,
  output logic              stall_o,
  input  logic              flush_i,
  input  logic              cdbValid_i,
  input  logic [ROBsizeLog-1:0] cdbTag_i,
  input  logic [63:0]       cdbData_i,
  output logic              issueValid_o,
  input  logic              issueReady_i,
  output logic [ROBsizeLog-1:0] issueTag_o,
  output logic [63:0]       issueVal1_o,
  output logic [63:0]       issueVal2_o,
  output logic [9:0]        issueCmd_o
);

  localparam int CNT_W = $clog2(RSentries + 1);
  localparam int IDX_W = $clog2(RSentries);

  rs_entry_t            entries      [RSentries];
  rs_entry_t            woken        [RSentries];
  rs_entry_t            shifted      [RSentries];
  rs_entry_t            entries_next [RSentries];
  rs_entry_t            new_entry;
  rs_entry_t            sel_entry;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     disp_idx;
  logic [RSentries-1:0] ready;
  logic [RSentries-1:0] sel_onehot;
  logic [IDX_W-1:0]     sel_idx;
  logic                 any_ready;
  logic                 take;
  logic                 disp;
  logic                 unused_bits;

  // Ready is judged on registered state only, so a wakeup never issues in its own cycle
  for (genvar gi = 0; gi < RSentries; gi++) begin : g_ready
    assign ready[gi] = (CNT_W'(gi) < count) && (entries[gi].tag1 == '0) && (entries[gi].tag2 == '0);
  end

  rs_ready_picker #(.N(RSentries), .IDX_W(IDX_W)) u_picker (
    .ready     (ready),
    .onehot    (sel_onehot),
    .index     (sel_idx),
    .any_ready (any_ready)
  );

  assign stall_o  = (count == CNT_W'(RSentries));
  assign take     = any_ready && (!issueValid_o || issueReady_i);
  assign disp     = writeEn_i && !stall_o;
  assign disp_idx = count - CNT_W'(take);

  // Incoming op, with same-cycle CDB bypass for either operand
  always_comb begin
    new_entry.rob_tag = robTag_i;
    new_entry.tag1    = tag1_i;
    new_entry.tag2    = tag2_i;
    new_entry.val1    = val1_i;
    new_entry.val2    = val2_i;
    new_entry.cmd     = commands_i;
    if (tag_hit(cdbValid_i, cdbTag_i, tag1_i)) begin
      new_entry.tag1       = '0;
      new_entry.val1[63:0] = cdbData_i;
    end
    if (tag_hit(cdbValid_i, cdbTag_i, tag2_i)) begin
      new_entry.tag2       = '0;
      new_entry.val2[63:0] = cdbData_i;
    end
  end

  // Wakeup of stored entries; bit 64 of each value is carried untouched
  always_comb begin
    for (int i = 0; i < RSentries; i++) begin
      woken[i] = entries[i];
      if (tag_hit(cdbValid_i, cdbTag_i, entries[i].tag1)) begin
        woken[i].tag1       = '0;
        woken[i].val1[63:0] = cdbData_i;
      end
      if (tag_hit(cdbValid_i, cdbTag_i, entries[i].tag2)) begin
        woken[i].tag2       = '0;
        woken[i].val2[63:0] = cdbData_i;
      end
    end
  end

  // Collapse above the selected slot, then append the dispatched op at the post-collapse tail
  always_comb begin
    for (int i = 0; i < RSentries - 1; i++) begin
      shifted[i] = (take && (i >= int'(sel_idx))) ? woken[i + 1] : woken[i];
    end
    shifted[RSentries-1] = woken[RSentries-1];
    for (int i = 0; i < RSentries; i++) begin
      entries_next[i] = (disp && (CNT_W'(i) == disp_idx)) ? new_entry : shifted[i];
    end
  end

  // One-hot AND-OR mux of the selected entry into the output register
  always_comb begin
    sel_entry = '0;
    for (int i = 0; i < RSentries; i++) begin
      if (sel_onehot[i]) sel_entry = sel_entry | entries[i];
    end
  end

  // Selected entry always has zero tags and the issue port has no bit 64
  assign unused_bits = ^{sel_entry.tag1, sel_entry.tag2, sel_entry.val1[64], sel_entry.val2[64]};

  // Queue, count and output register; flush overrides everything but reset
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < RSentries; i++) entries[i] <= '0;
      count        <= '0;
      issueValid_o <= 1'b0;
      issueTag_o   <= '0;
      issueVal1_o  <= '0;
      issueVal2_o  <= '0;
      issueCmd_o   <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < RSentries; i++) entries[i] <= '0;
      count        <= '0;
      issueValid_o <= 1'b0;
      issueTag_o   <= '0;
      issueVal1_o  <= '0;
      issueVal2_o  <= '0;
      issueCmd_o   <= '0;
    end else begin
      for (int i = 0; i < RSentries; i++) entries[i] <= entries_next[i];
      count <= count + CNT_W'(disp) - CNT_W'(take);
      if (take) begin
        issueValid_o <= 1'b1;
        issueTag_o   <= sel_entry.rob_tag;
        issueVal1_o  <= sel_entry.val1[63:0];
        issueVal2_o  <= sel_entry.val2[63:0];
        issueCmd_o   <= sel_entry.cmd;
      end else if (issueReady_i) begin
        issueValid_o <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Decode must never dispatch into a full station
  full_dispatch_check: assert property (@(posedge clk_i) disable iff (!reset_i) !(writeEn_i && stall_o))
    else $error("reservation_station: dispatch while full");
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: dispatch/issue latency, CDB wakeup
// and bypass, full/stall behaviour, output back-pressure, flush and reset.
module tb_reservation_station;
  import rs_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        writeEn_i = 1'b0;
  logic [ROBsizeLog-1:0] robTag_i = '0, tag1_i = '0, tag2_i = '0;
  logic [64:0] val1_i = '0, val2_i = '0;
  logic [9:0]  commands_i = '0;
  logic        stall_o;
  logic        flush_i = 1'b0;
  logic        cdbValid_i = 1'b0;
  logic [ROBsizeLog-1:0] cdbTag_i = '0;
  logic [63:0] cdbData_i = '0;
  logic        issueValid_o;
  logic        issueReady_i = 1'b0;
  logic [ROBsizeLog-1:0] issueTag_o;
  logic [63:0] issueVal1_o, issueVal2_o;
  logic [9:0]  issueCmd_o;

  int n_cmp = 0;
  int n_err = 0;

  reservation_station #(.RSentries(4)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .writeEn_i    (writeEn_i),
    .robTag_i     (robTag_i),
    .tag1_i       (tag1_i),
    .tag2_i       (tag2_i),
    .val1_i       (val1_i),
    .val2_i       (val2_i),
    .commands_i   (commands_i),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .cdbValid_i   (cdbValid_i),
    .cdbTag_i     (cdbTag_i),
    .cdbData_i    (cdbData_i),
    .issueValid_o (issueValid_o),
    .issueReady_i (issueReady_i),
    .issueTag_o   (issueTag_o),
    .issueVal1_o  (issueVal1_o),
    .issueVal2_o  (issueVal2_o),
    .issueCmd_o   (issueCmd_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one rising edge and settle
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present a dispatch for one edge
  task automatic dispatch(input int rob, input int t1, input int t2,
                          input logic [63:0] v1, input logic [63:0] v2, input logic [9:0] cmd);
    writeEn_i  = 1'b1;
    robTag_i   = ROBsizeLog'(rob);
    tag1_i     = ROBsizeLog'(t1);
    tag2_i     = ROBsizeLog'(t2);
    val1_i     = {1'b0, v1};
    val2_i     = {1'b0, v2};
    commands_i = cmd;
    step();
    writeEn_i  = 1'b0;
  endtask

  // Broadcast one CDB result for one edge
  task automatic cdb(input int t, input logic [63:0] d);
    cdbValid_i = 1'b1;
    cdbTag_i   = ROBsizeLog'(t);
    cdbData_i  = d;
    step();
    cdbValid_i = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check_val("rst_valid", 64'(issueValid_o), 64'd0);
    check_val("rst_stall", 64'(stall_o), 64'd0);
    check_val("rst_tag",   64'(issueTag_o), 64'd0);
    check_val("rst_val1",  issueVal1_o, 64'd0);
    check_val("rst_count", 64'(dut.count), 64'd0);
    reset_i = 1'b1;
    step();

    // 1: ready op issues the cycle after dispatch
    issueReady_i = 1'b1;
    dispatch(5, 0, 0, 64'd3, 64'd4, 10'h155);
    check_val("t1_no_issue_same_cycle", 64'(issueValid_o), 64'd0);
    check_val("t1_count_1", 64'(dut.count), 64'd1);
    step();
    check_val("t1_valid", 64'(issueValid_o), 64'd1);
    check_val("t1_tag",   64'(issueTag_o), 64'd5);
    check_val("t1_val1",  issueVal1_o, 64'd3);
    check_val("t1_val2",  issueVal2_o, 64'd4);
    check_val("t1_cmd",   64'(issueCmd_o), 64'h155);
    check_val("t1_count_0", 64'(dut.count), 64'd0);
    step();
    check_val("t1_drain", 64'(issueValid_o), 64'd0);

    // 2: blocked op woken by CDB two cycles later
    dispatch(6, 7, 0, 64'h11, 64'h22, 10'h003);
    step();
    check_val("t2_blocked", 64'(issueValid_o), 64'd0);
    cdb(7, 64'hAA);
    check_val("t2_no_issue_at_wake", 64'(issueValid_o), 64'd0);
    step();
    check_val("t2_valid", 64'(issueValid_o), 64'd1);
    check_val("t2_tag",   64'(issueTag_o), 64'd6);
    check_val("t2_val1",  issueVal1_o, 64'hAA);
    check_val("t2_val2",  issueVal2_o, 64'h22);
    step();

    // 3: dispatch bypass from a same-cycle CDB broadcast
    cdbValid_i = 1'b1; cdbTag_i = ROBsizeLog'(9); cdbData_i = 64'h55;
    dispatch(8, 0, 9, 64'h1, 64'h2, 10'h010);
    cdbValid_i = 1'b0;
    check_val("t3_no_issue_same_cycle", 64'(issueValid_o), 64'd0);
    step();
    check_val("t3_valid", 64'(issueValid_o), 64'd1);
    check_val("t3_tag",   64'(issueTag_o), 64'd8);
    check_val("t3_val1",  issueVal1_o, 64'h1);
    check_val("t3_val2",  issueVal2_o, 64'h55);
    step();

    // 4: fill with blocked ops, wake the third, then drain in age order
    dispatch(10, 20, 0, 64'h0, 64'hA0, 10'h000);
    dispatch(11, 21, 0, 64'h0, 64'hA1, 10'h000);
    dispatch(12, 22, 0, 64'h0, 64'hA2, 10'h000);
    check_val("t4_not_full", 64'(stall_o), 64'd0);
    dispatch(13, 23, 0, 64'h0, 64'hA3, 10'h000);
    check_val("t4_full", 64'(stall_o), 64'd1);
    check_val("t4_count", 64'(dut.count), 64'd4);
    cdb(22, 64'h122);
    check_val("t4_stall_held", 64'(stall_o), 64'd1);
    step();
    check_val("t4_mid_valid", 64'(issueValid_o), 64'd1);
    check_val("t4_mid_tag",   64'(issueTag_o), 64'd12);
    check_val("t4_mid_val1",  issueVal1_o, 64'h122);
    check_val("t4_stall_drop", 64'(stall_o), 64'd0);
    issueReady_i = 1'b0;
    cdb(23, 64'h123);
    cdb(20, 64'h120);
    cdb(21, 64'h121);
    check_val("t4_held_tag", 64'(issueTag_o), 64'd12);
    issueReady_i = 1'b1;
    step();
    check_val("t4_order0_tag",  64'(issueTag_o), 64'd10);
    check_val("t4_order0_val1", issueVal1_o, 64'h120);
    step();
    check_val("t4_order1_tag",  64'(issueTag_o), 64'd11);
    check_val("t4_order1_val2", issueVal2_o, 64'hA1);
    step();
    check_val("t4_order2_tag",  64'(issueTag_o), 64'd13);
    check_val("t4_order2_val1", issueVal1_o, 64'h123);
    step();
    check_val("t4_empty_valid", 64'(issueValid_o), 64'd0);
    check_val("t4_empty_count", 64'(dut.count), 64'd0);

    // 5: back-pressure holds outputs; two ready ops then drain back-to-back
    issueReady_i = 1'b0;
    dispatch(1, 0, 0, 64'h10, 64'h11, 10'h001);
    dispatch(2, 0, 0, 64'h20, 64'h21, 10'h002);
    check_val("t5_count_after_swap", 64'(dut.count), 64'd1);
    for (int c = 0; c < 3; c++) begin
      check_val($sformatf("t5_hold%0d_valid", c), 64'(issueValid_o), 64'd1);
      check_val($sformatf("t5_hold%0d_tag", c),   64'(issueTag_o), 64'd1);
      check_val($sformatf("t5_hold%0d_val1", c),  issueVal1_o, 64'h10);
      step();
    end
    issueReady_i = 1'b1;
    step();
    check_val("t5_next_tag",  64'(issueTag_o), 64'd2);
    check_val("t5_next_val1", issueVal1_o, 64'h20);
    check_val("t5_next_cmd",  64'(issueCmd_o), 64'h002);
    step();
    check_val("t5_drain", 64'(issueValid_o), 64'd0);

    // 6: flush with three entries and a held output
    issueReady_i = 1'b0;
    dispatch(1, 0, 0, 64'h1, 64'h1, 10'h000);
    dispatch(2, 0, 0, 64'h2, 64'h2, 10'h000);
    dispatch(3, 0, 0, 64'h3, 64'h3, 10'h000);
    dispatch(4, 0, 0, 64'h4, 64'h4, 10'h000);
    check_val("t6_pre_count", 64'(dut.count), 64'd3);
    check_val("t6_pre_valid", 64'(issueValid_o), 64'd1);
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    check_val("t6_flush_count", 64'(dut.count), 64'd0);
    check_val("t6_flush_valid", 64'(issueValid_o), 64'd0);
    check_val("t6_flush_stall", 64'(stall_o), 64'd0);

    // Asynchronous reset in the middle of a cycle
    dispatch(7, 0, 0, 64'h77, 64'h78, 10'h3FF);
    step();
    check_val("t6_pre_rst_valid", 64'(issueValid_o), 64'd1);
    #2;
    reset_i = 1'b0;
    #1;
    check_val("t6_rst_valid", 64'(issueValid_o), 64'd0);
    check_val("t6_rst_tag",   64'(issueTag_o), 64'd0);
    check_val("t6_rst_val1",  issueVal1_o, 64'd0);
    check_val("t6_rst_cmd",   64'(issueCmd_o), 64'd0);
    check_val("t6_rst_count", 64'(dut.count), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
